conv_accumulator: RTL and testbench
===================================

CONV_ACCUMULATOR -- requirements
Module: conv_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: operand width of the upstream multiplier; product width is 2*DATA_WIDTH.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 72: accumulator and result width, which SHALL be at least 2*DATA_WIDTH.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16: width of the per-window product counter.
REQ-004 The block SHALL have input clk, 1 bit: the clock.
REQ-005 The block SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have input in_valid, 1 bit: in_product holds a valid unsigned product this cycle.
REQ-007 The block SHALL have input in_last, 1 bit, qualified by in_valid: this product closes the current convolution window.
REQ-008 The block SHALL have input in_product, 2*DATA_WIDTH bits: unsigned product from the multiplier stage.
REQ-009 The block SHALL have output out_valid, 1 bit: the result FIFO head is valid.
REQ-010 The block SHALL have input out_ready, 1 bit: the consumer accepts the FIFO head.
REQ-011 The block SHALL have output out_sum, ACC_WIDTH bits: the window sum at the FIFO head.
REQ-012 The block SHALL have output out_count, CNT_WIDTH bits: the number of products in that window.
REQ-013 The block SHALL have output out_sat, 1 bit: that window's sum saturated.
REQ-014 The block SHALL have output overflow, 1 bit, sticky: a completed window was dropped because the FIFO was full.
REQ-015 The block SHALL have output busy, 1 bit: a window is partially accumulated (FSM in ACCUM).

Function
REQ-016 Input SHALL never be back-pressured; every in_valid beat SHALL be consumed the cycle it is presented (the upstream stage is free-running).
REQ-017 The FSM SHALL have two states: IDLE (acc=0, cnt=0) and ACCUM.
REQ-018 IDLE with in_valid&!in_last SHALL load acc=product, cnt=1, and go to ACCUM.
REQ-019 ACCUM with in_valid&!in_last SHALL set acc=acc+product and cnt=cnt+1.
REQ-020 A beat with in_valid&in_last, in either state, SHALL push {acc+product (or product if IDLE), cnt+1, sat} to the FIFO, clear acc/cnt/sat in the same cycle, and go to IDLE, so a new window may start on the next cycle.
REQ-021 A cycle with in_valid=0 SHALL hold acc, cnt and state.
REQ-022 Accumulation SHALL be unsigned and zero-extended to ACC_WIDTH; on carry-out, acc SHALL clamp to all-ones and the window sat flag SHALL set and stay set until the window is pushed.
REQ-023 cnt SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-024 Latency SHALL be 1 cycle: the result of an in_last beat at edge N SHALL be visible at the FIFO head after edge N when the FIFO was empty.
REQ-025 The result FIFO SHALL have depth 2 and be first-word-fall-through; a pop SHALL occur on out_valid&out_ready.
REQ-026 A push to a full FIFO with no pop in the same cycle SHALL drop the result and set overflow; FIFO contents SHALL be unchanged.
REQ-027 A simultaneous push and pop SHALL be legal at any occupancy, including full, and SHALL NOT set overflow.
REQ-028 out_sum, out_count and out_sat SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 overflow SHALL clear only on rst.

Reset
REQ-030 rst SHALL asynchronously force: state IDLE, acc=0, cnt=0, sat=0, FIFO empty, out_valid=0, out_sum=0, out_count=0, out_sat=0, overflow=0, busy=0.
REQ-031 A rst asserted mid-window SHALL discard the partial sum; the first beat after release SHALL start a new window.

Structure
REQ-032 Package conv_acc_pkg SHALL hold the default widths, the FIFO depth constant, and the FSM state type.
REQ-033 The FIFO SHALL be a separate sub-module, conv_result_fifo (parameterized width, depth 2, valid/ready, full/empty flags).

Verification (DATA_WIDTH=8, ACC_WIDTH=17, CNT_WIDTH=4)
REQ-034 Products 6, 10, 14 (last on 14), out_ready=1 -> one result with sum=30, count=3, sat=0, one cycle after the last beat.
REQ-035 A single beat 200 with last -> sum=200, count=1; a back-to-back next window 5,5(last) -> sum=10, count=2, with no gap between windows.
REQ-036 out_ready=0 and three one-beat windows 1, 2, 3 -> FIFO holds 1,2 and overflow=1; after out_ready=1 -> outputs 1 then 2, and 3 is absent.
REQ-037 Three 65025 products (last on third), ACC_WIDTH=17 -> sum=131071, sat=1; the next window has sat=0.
REQ-038 17 non-last beats of 1 then last 1 -> count=15 (saturated), sum=18.
REQ-039 rst pulsed after 2 of 4 beats -> no output for that window; a following window 3,4(last) -> sum=7, count=2.

Source files
------------

// File: rtl/conv_acc_pkg.sv
// Shared widths, result FIFO depth and accumulator FSM state type.
package conv_acc_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ACC_WIDTH  = 72;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int FIFO_DEPTH     = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

endpackage

// File: rtl/conv_accumulator_if.sv
// Product input stream and result output stream of the convolution accumulator.
interface conv_accumulator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 72,
    parameter int CNT_WIDTH  = 16
);
    logic                    in_valid;
    logic                    in_last;
    logic [2*DATA_WIDTH-1:0] in_product;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_WIDTH-1:0]    out_sum;
    logic [CNT_WIDTH-1:0]    out_count;
    logic                    out_sat;

    // Upstream multiplier feeds products, downstream consumer takes results.
    modport master (
        output in_valid, in_last, in_product, out_ready,
        input  out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_last, in_product, out_ready,
        output out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/conv_result_fifo.sv
// Two-entry first-word-fall-through result FIFO; slot0 is always the head.
module conv_result_fifo
    import conv_acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] slot0, slot1;
    logic [1:0]       count;
    logic             pop, push;

    assign full     = (count == 2'(FIFO_DEPTH));
    assign empty    = (count == 2'd0);
    assign out_data = slot0;
    assign pop      = !empty && out_ready;
    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign push     = in_valid && (!full || pop);

    // Shift-style storage: pops move slot1 forward, pushes land behind the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= in_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= in_data;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (empty) slot0 <= in_data;
                    else       slot1 <= in_data;
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/conv_accumulator.sv
// Window accumulator for convolution products: sums unsigned products until
// in_last, then hands {sum, count, sat} to a small result FIFO. Never stalls.
module conv_accumulator
    import conv_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    conv_accumulator_if.slave   bus,
    output logic                overflow,
    output logic                busy
);
    localparam int RES_W = 1 + CNT_WIDTH + ACC_WIDTH;

    acc_state_e           state, state_nxt;
    logic [ACC_WIDTH-1:0] acc, acc_nxt, acc_add;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
    logic                 sat, sat_nxt, sat_add;
    logic [ACC_WIDTH:0]   sum;
    logic                 push;
    logic [RES_W-1:0]     push_data, head_data;
    logic                 fifo_full, fifo_empty;

    // Saturating add of the current product; acc is zero in IDLE so one adder serves both states.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, ACC_WIDTH'(bus.in_product)};
        acc_add = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
        sat_add = sat | sum[ACC_WIDTH];
        cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    end

    // Next-state and window datapath: last beats push and clear in the same cycle.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sat_nxt   = sat;
        push      = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_last) begin
                push      = 1'b1;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                sat_nxt   = 1'b0;
                state_nxt = IDLE;
            end else begin
                acc_nxt = acc_add;
                cnt_nxt = cnt_inc;
                sat_nxt = sat_add;
                case (state)
                    IDLE:    state_nxt = ACCUM;
                    ACCUM:   state_nxt = ACCUM;
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // State and window registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sat   <= sat_nxt;
        end
    end

    // Sticky drop flag: a completed window found the FIFO full with no pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (push && fifo_full && !bus.out_ready)
            overflow <= 1'b1;
    end

    assign push_data = {sat_add, cnt_inc, acc_add};
    assign busy      = (state == ACCUM);

    conv_result_fifo #(.WIDTH(RES_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_data   (push_data),
        .out_ready (bus.out_ready),
        .out_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign {bus.out_sat, bus.out_count, bus.out_sum} = head_data;
endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator at DATA_WIDTH=8, ACC_WIDTH=17, CNT_WIDTH=4.
module tb_conv_accumulator;
    localparam int DW = 8;
    localparam int AW = 17;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overflow, busy;
    int   total  = 0;
    int   passed = 0;

    conv_accumulator_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    conv_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        last;
        logic [15:0] prod;
        logic        rdy;
        logic        e_vld;
        logic [16:0] e_sum;
        logic [3:0]  e_cnt;
        logic        e_sat;
        logic        e_busy;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic drv(input logic v, input logic l, input logic [15:0] p, input logic r);
        bus.in_valid   = v;
        bus.in_last    = l;
        bus.in_product = p;
        bus.out_ready  = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string nm, input logic v, input logic [16:0] s,
                            input logic [3:0] c, input logic st);
        chk({nm, ".valid"}, 32'(bus.out_valid), 32'(v));
        if (v) begin
            chk({nm, ".sum"}, 32'(bus.out_sum), 32'(s));
            chk({nm, ".count"}, 32'(bus.out_count), 32'(c));
            chk({nm, ".sat"}, 32'(bus.out_sat), 32'(st));
        end
    endtask

    initial begin
        // vld last prod rdy | e_vld e_sum e_cnt e_sat e_busy
        vecs[0]  = '{1, 0, 6,     1, 0, 0,      0, 0, 1};
        vecs[1]  = '{1, 0, 10,    1, 0, 0,      0, 0, 1};
        vecs[2]  = '{1, 1, 14,    1, 1, 30,     3, 0, 0};
        vecs[3]  = '{0, 0, 0,     1, 0, 0,      0, 0, 0};
        vecs[4]  = '{1, 1, 200,   1, 1, 200,    1, 0, 0};
        vecs[5]  = '{1, 0, 5,     1, 0, 0,      0, 0, 1};
        vecs[6]  = '{1, 1, 5,     1, 1, 10,     2, 0, 0};
        vecs[7]  = '{0, 0, 0,     1, 0, 0,      0, 0, 0};
        vecs[8]  = '{1, 0, 65025, 1, 0, 0,      0, 0, 1};
        vecs[9]  = '{1, 0, 65025, 1, 0, 0,      0, 0, 1};
        vecs[10] = '{1, 1, 65025, 1, 1, 131071, 3, 1, 0};
        vecs[11] = '{1, 1, 7,     1, 1, 7,      1, 0, 0};
        vecs[12] = '{0, 0, 0,     1, 0, 0,      0, 0, 0};

        drv(0, 0, 0, 0);
        #12;
        chk("rst.valid", 32'(bus.out_valid), 0);
        chk("rst.sum", 32'(bus.out_sum), 0);
        chk("rst.count", 32'(bus.out_count), 0);
        chk("rst.sat", 32'(bus.out_sat), 0);
        chk("rst.overflow", 32'(overflow), 0);
        chk("rst.busy", 32'(busy), 0);
        rst = 1'b0;

        // Table: one cycle per record, outputs checked just after the edge.
        for (int i = 0; i < 13; i++) begin
            drv(vecs[i].vld, vecs[i].last, vecs[i].prod, vecs[i].rdy);
            step();
            chk_head($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_sum,
                     vecs[i].e_cnt, vecs[i].e_sat);
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
        end

        // Push and pop together while full: no drop, order kept.
        drv(1, 1, 4, 0); step();
        drv(1, 1, 5, 0); step();
        chk_head("full.head", 1, 4, 1, 0);
        drv(1, 1, 6, 1); step();
        chk_head("pushpop.head", 1, 5, 1, 0);
        chk("pushpop.overflow", 32'(overflow), 0);
        drv(0, 0, 0, 0); step();
        chk_head("stall.head", 1, 5, 1, 0);
        drv(0, 0, 0, 1); step();
        chk_head("drain.head", 1, 6, 1, 0);
        step();
        chk_head("drain.empty", 0, 0, 0, 0);

        // Three one-beat windows into a stalled FIFO: third dropped.
        drv(1, 1, 1, 0); step();
        drv(1, 1, 2, 0); step();
        drv(1, 1, 3, 0); step();
        chk("ovf.overflow", 32'(overflow), 1);
        chk_head("ovf.head0", 1, 1, 1, 0);
        drv(0, 0, 0, 1); step();
        chk_head("ovf.head1", 1, 2, 1, 0);
        step();
        chk_head("ovf.empty", 0, 0, 0, 0);
        chk("ovf.sticky", 32'(overflow), 1);

        // Count saturation: 17 plain beats then last, all ones.
        for (int i = 0; i < 17; i++) begin
            drv(1, 0, 1, 1); step();
        end
        chk("cntsat.busy", 32'(busy), 1);
        drv(1, 1, 1, 1); step();
        chk_head("cntsat", 1, 18, 15, 0);
        drv(0, 0, 0, 1); step();

        // Reset mid-window discards the partial sum and clears overflow.
        drv(1, 0, 1, 1); step();
        drv(1, 0, 2, 1); step();
        chk("midrst.busy_before", 32'(busy), 1);
        drv(0, 0, 0, 1);
        rst = 1'b1;
        #2;
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.valid", 32'(bus.out_valid), 0);
        chk("midrst.overflow", 32'(overflow), 0);
        rst = 1'b0;
        step();
        chk_head("midrst.nohead", 0, 0, 0, 0);
        drv(1, 0, 3, 1); step();
        drv(1, 1, 4, 1); step();
        chk_head("midrst.next", 1, 7, 2, 0);
        drv(0, 0, 0, 1); step();
        chk_head("midrst.empty", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
